// File: rtl/substructor_pkg.sv
// Shared types and defaults for the chunked subtract scheduler.
package substructor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_W     = 64;
    localparam int DEF_CHUNK = 16;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/substructor_chunk.sv
// Combinational CHUNK-bit subtract stage: {bout, diff} = a - b - bin.
module substructor_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             bin_i,
    output logic [CHUNK-1:0] diff_o,
    output logic             bout_o
);

    logic [CHUNK:0] full;

    // The extra top bit goes to 1 exactly when the true result is negative.
    assign full   = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
    assign diff_o = full[CHUNK-1:0];
    assign bout_o = full[CHUNK];

endmodule

// File: rtl/substructor_sched.sv
// Round-robin scheduler feeding W-bit subtractions through one shared chunk stage.
// Optional embedded properties: define SUBSTRUCTOR_SCHED_FORMAL_EN.
module substructor_sched
    import substructor_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int W     = DEF_W,
    parameter int CHUNK = DEF_CHUNK,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*W-1:0]    req_a_i,
    input  logic [NREQ*W-1:0]    req_b_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [ID_W-1:0]      resp_id_o,
    output logic [W-1:0]         resp_diff_o,
    output logic                 resp_borrow_o
);

    localparam int NCHUNK = W / CHUNK;
    localparam int K_W    = id_width(NCHUNK);

    generate
        if ((W % CHUNK) != 0 || W < CHUNK) begin : g_bad_width
            $error("substructor_sched: W must be a non-zero multiple of CHUNK");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("substructor_sched: NREQ must be in 2..8");
        end
    endgenerate

    sched_state_t   state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] id_q;
    logic [K_W-1:0]  k_q;
    logic            borrow_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    diff_q;
    logic            resp_valid_q;
    logic            resp_borrow_q;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr.
    logic [2*NREQ-1:0] vld_dbl;
    logic [NREQ-1:0]   vld_rot;
    logic [ID_W:0]     grant_sum;
    logic [ID_W-1:0]   grant;
    logic              grant_vld;
    logic [ID_W-1:0]   next_ptr;

    assign vld_dbl = {req_valid_i, req_valid_i};
    assign vld_rot = vld_dbl[rr_ptr_q +: NREQ];

    always_comb begin
        grant_sum = '0;
        grant_vld = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (vld_rot[j]) begin
                grant_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(j);
                grant_vld = 1'b1;
            end
        end
        if (grant_sum >= (ID_W+1)'(NREQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(NREQ);
        end
        grant = grant_sum[ID_W-1:0];
    end

    assign next_ptr = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && grant_vld && !rst_i) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_bout;

    substructor_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (a_q[k_q*CHUNK +: CHUNK]),
        .b_i    (b_q[k_q*CHUNK +: CHUNK]),
        .bin_i  (borrow_q),
        .diff_o (chunk_diff),
        .bout_o (chunk_bout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            k_q           <= '0;
            borrow_q      <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            diff_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        a_q      <= req_a_i[grant*W +: W];
                        b_q      <= req_b_i[grant*W +: W];
                        id_q     <= grant;
                        k_q      <= '0;
                        borrow_q <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    diff_q[k_q*CHUNK +: CHUNK] <= chunk_diff;
                    borrow_q <= chunk_bout;
                    k_q      <= k_q + 1'b1;
                    if (k_q == K_W'(NCHUNK - 1)) begin
                        resp_borrow_q <= chunk_bout;
                        resp_valid_q  <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= next_ptr;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_id_o     = id_q;
    assign resp_diff_o   = diff_q;
    assign resp_borrow_o = resp_borrow_q;

`ifdef SUBSTRUCTOR_SCHED_FORMAL_EN
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));

    a_result: assert property (@(posedge clk_i) disable iff (rst_i)
        resp_valid_o |-> (resp_diff_o == W'(a_q - b_q)) && (resp_borrow_o == (a_q < b_q)));

    a_resp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        resp_valid_o && !resp_ready_i |=>
            $stable({resp_valid_o, resp_id_o, resp_diff_o, resp_borrow_o}));

    // Grants that went elsewhere while each requester was waiting.
    logic [3:0] wait_cnt_q [NREQ];
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_fair
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    wait_cnt_q[gi] <= '0;
                end else if (state_q == IDLE && grant_vld) begin
                    if (grant == ID_W'(gi)) begin
                        wait_cnt_q[gi] <= '0;
                    end else if (req_valid_i[gi]) begin
                        wait_cnt_q[gi] <= wait_cnt_q[gi] + 4'd1;
                    end
                end
            end
            a_no_starve: assert property (@(posedge clk_i) disable iff (rst_i)
                wait_cnt_q[gi] <= 4'(NREQ - 1));
        end
    endgenerate

    c_borrow_case: cover property (@(posedge clk_i) disable iff (rst_i)
        resp_valid_o && resp_ready_i && a_q == '0 && b_q == W'(64'hFFFF_FFFF_FFFF_5556));
`endif

endmodule

// File: tb/tb_substructor_sched.sv
// Randomized self-checking bench for substructor_sched against a wide-arithmetic reference model.
module tb_substructor_sched;

    localparam int NREQ   = 4;
    localparam int W      = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = W / CHUNK;
    localparam int ID_W   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [W-1:0]        resp_diff;
    logic                resp_borrow;

    logic [W-1:0]        aa [NREQ];
    logic [W-1:0]        bb [NREQ];
    logic [NREQ-1:0]     va;
    int                  rr_m;
    int                  n_cmp = 0;
    int                  n_bad = 0;

    always #5 clk = ~clk;

    assign req_valid = va;
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = aa[i];
            req_b[i*W +: W] = bb[i];
        end
    end

    substructor_sched #(
        .NREQ  (NREQ),
        .W     (W),
        .CHUNK (CHUNK)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_id_o     (resp_id),
        .resp_diff_o   (resp_diff),
        .resp_borrow_o (resp_borrow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first valid requester at or after the pointer, wrapping.
    function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
        for (int j = 0; j < NREQ; j++) begin
            if (v[(ptr + j) % NREQ]) return (ptr + j) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic new_ops(input int i);
        aa[i] = rnd64();
        bb[i] = ($urandom_range(0, 5) == 0) ? aa[i] : rnd64();
    endtask

    // Entered just after a rising edge with inputs settled; leaves just after the response handshake edge.
    task automatic serve_one(input int hold, input bit cont,
                             output logic [ID_W-1:0] got_id, output logic [W-1:0] got_diff,
                             output logic got_borrow);
        int          g;
        int          lat;
        logic [W-1:0] ea, eb, ed;
        logic        eb_flag;
        #1;
        got_id = '0; got_diff = '0; got_borrow = 1'b0;
        g = pick(rr_m, va);
        if (g < 0) begin
            $display("note: serve_one called with no valid requester");
            return;
        end
        check("req_ready", 64'(req_ready), 64'(1) << g);
        ea = aa[g];
        eb = bb[g];
        ed = ea - eb;
        eb_flag = (ea < eb);
        @(posedge clk); #1;
        new_ops(g);
        if (!cont) va[g] = 1'b0;
        check("ready_busy", 64'(req_ready), 64'd0);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(NCHUNK));
        got_id = resp_id;
        got_diff = resp_diff;
        got_borrow = resp_borrow;
        check("diff", resp_diff, ed);
        check("borrow", 64'(resp_borrow), 64'(eb_flag));
        check("id", 64'(resp_id), 64'(g));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_diff", resp_diff, ed);
            check("hold_ctl", 64'({resp_valid, resp_borrow, resp_id, req_ready}),
                  64'({1'b1, eb_flag, ID_W'(g), 4'b0000}));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_drop", 64'(resp_valid), 64'd0);
        rr_m = (g + 1) % NREQ;
        $display("op id=%0d a=%h b=%h diff=%h borrow=%0b hold=%0d", g, ea, eb, got_diff, got_borrow, hold);
        if (|va) begin
            check("next_grant", 64'(req_ready), 64'(1) << pick(rr_m, va));
        end
    endtask

    initial begin
        logic [ID_W-1:0] oid;
        logic [W-1:0]    od;
        logic            ob;
        int              rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        resp_ready = 1'b0;
        rr_m = 0;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        va = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_id", 64'(resp_id), 64'd0);
        check("rst_diff", resp_diff, 64'd0);
        check("rst_borrow", 64'(resp_borrow), 64'd0);
        rst = 1'b0;

        // Round robin with all requesters continuously valid.
        va = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            serve_one(0, 1'b1, oid, od, ob);
            check("rr_seq", 64'(oid), 64'(rr_exp[n]));
        end
        va = 4'b0000;

        aa[0] = 64'd0; bb[0] = 64'hFFFF_FFFF_FFFF_5556; va = 4'b0001;
        serve_one(0, 1'b0, oid, od, ob);
        check("dir1_diff", od, 64'h0000_0000_0000_AAAA);
        check("dir1_borrow", 64'(ob), 64'd1);
        check("dir1_id", 64'(oid), 64'd0);

        aa[0] = 64'h0001_0000_0000_0000; bb[0] = 64'd1; va = 4'b0001;
        serve_one(0, 1'b0, oid, od, ob);
        check("chain_diff", od, 64'h0000_FFFF_FFFF_FFFF);
        check("chain_borrow", 64'(ob), 64'd0);

        aa[0] = 64'hDEAD_BEEF_0123_4567; bb[0] = 64'hDEAD_BEEF_0123_4567; va = 4'b0001;
        serve_one(0, 1'b0, oid, od, ob);
        check("eq_diff", od, 64'd0);
        check("eq_borrow", 64'(ob), 64'd0);

        // Backpressure for 10 cycles with a second requester waiting.
        new_ops(1); new_ops(2); va = 4'b0110;
        serve_one(10, 1'b0, oid, od, ob);
        serve_one(0, 1'b0, oid, od, ob);

        // Push the pointer to 3, then abort an operation of requester 1 in its second CALC cycle.
        new_ops(2); va = 4'b0100;
        serve_one(0, 1'b0, oid, od, ob);
        new_ops(1); va = 4'b0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(resp_valid), 64'd0);
        check("abort_id", 64'(resp_id), 64'd0);
        check("abort_diff", resp_diff, 64'd0);
        check("abort_borrow", 64'(resp_borrow), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rr_m = 0;
        new_ops(0); new_ops(3); va = 4'b1011;
        check("post_rst_valid", 64'(resp_valid), 64'd0);
        serve_one(0, 1'b0, oid, od, ob);
        check("post_rst_grant", 64'(oid), 64'd0);
        serve_one(0, 1'b0, oid, od, ob);
        serve_one(0, 1'b0, oid, od, ob);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!va[i] && $urandom_range(0, 1) == 1) begin
                    new_ops(i);
                    va[i] = 1'b1;
                end
            end
            if (va == '0) begin
                va[$urandom_range(0, NREQ - 1)] = 1'b1;
            end
            serve_one($urandom_range(0, 3), ($urandom_range(0, 3) == 0), oid, od, ob);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/substructor_sched.md
# substructor_sched

Round-robin scheduler that shares one narrow CHUNK-bit subtract stage among NREQ requesters and sequences full W-bit subtractions through it chunk by chunk, least-significant chunk first, with borrow chaining. It sits between requester ports and the subtractor datapath. It returns a − b (mod 2^W), the unsigned borrow, and the requester id over a valid/ready response channel.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- W, default 64: operand width; must be a multiple of CHUNK, otherwise elaboration error.
- CHUNK, default 16: subtract-stage width; NCHUNK = W/CHUNK.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  minuend of requester i at bits [i*W +: W].
- req_b  in  NREQ*W  subtrahend, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  max(1,$clog2(NREQ))  index of the served requester.
- resp_diff  out  W  a − b mod 2^W.
- resp_borrow  out  1  1 iff a < b (unsigned).

## Operation
- FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: the grant goes to the first i with req_valid[i], searching from rr_ptr upward with wrap. req_ready[grant] = 1 combinationally; all other req_ready bits are 0. On handshake the block latches a, b and id, clears chunk counter k and borrow, and moves to CALC. If no request is valid, it stays in IDLE.
- CALC: each cycle computes {borrow', d} = a[k] − b[k] − borrow on the chunk stage. It writes d into diff chunk k and increments k. After chunk NCHUNK−1 it latches the final borrow into resp_borrow and moves to DONE.
- DONE: resp_valid = 1. Outputs hold stable until resp_ready. On handshake the FSM returns to IDLE and rr_ptr becomes (id+1) mod NREQ.
- req_ready is 0 in CALC and DONE. Requesters must hold req_valid and operands until accepted.
- Operands are sampled only at acceptance. Changes to req_a/req_b afterwards do not affect the result.
- Reset values: req_ready 0, resp_valid 0, resp_id 0, resp_diff 0, resp_borrow 0, rr_ptr 0, k 0.
- Reset asserted mid-operation aborts the operation immediately. No response is produced for it, and the requester must re-request.

## Timing
- Accept handshake at cycle T. CALC occupies T+1..T+NCHUNK. resp_valid rises at T+NCHUNK+1.
- Default configuration: 4 CALC cycles; resp_valid at T+5.
- If resp_ready is high when resp_valid rises, handshake occurs that cycle. The next accept can then occur at T+NCHUNK+2.
- Peak throughput is one operation per NCHUNK+2 cycles.
- Backpressure: DONE persists indefinitely while resp_ready = 0, and no new request is accepted.
- Fairness: a continuously asserted requester waits at most NREQ−1 operations.

## Configuration
- SUBSTRUCTOR_SCHED_FORMAL_EN defined: the block compiles in embedded formal properties:
  - at most one req_ready bit set;
  - resp_diff == a_lat − b_lat and resp_borrow == (a_lat < b_lat) whenever resp_valid;
  - resp_* stable while resp_valid && !resp_ready;
  - no requester starved beyond NREQ−1 operations;
  - a cover of completing a=0, b=64'hFFFF_FFFF_FFFF_5556.
- Not defined: no properties and no extra logic. Ports and behaviour are identical in both builds.

## Structure
- Shared package substructor_pkg holds:
  - the state enum sched_state_t (IDLE, CALC, DONE);
  - the default W/CHUNK/NREQ constants;
  - the function id_width(n) = max(1,$clog2(n)).
- One sub-module, substructor_chunk: combinational CHUNK-bit a − b − bin producing diff and bout. It is instantiated once and shared across all chunks.

## Test plan
- Single request: requester 0 with a=0, b=64'hFFFF_FFFF_FFFF_5556 → resp_valid at T+5, diff=64'h0000_0000_0000_AAAA, borrow=1, id=0.
- Chunk carry chain: a=64'h0001_0000_0000_0000, b=1 → diff=64'h0000_FFFF_FFFF_FFFF, borrow=0. This exercises the borrow across all chunk boundaries.
- Round-robin: all four requesters valid continuously → resp_id sequence 0,1,2,3,0. Each req_ready pulse is one cycle and one-hot.
- Backpressure: hold resp_ready=0 for 10 cycles after completion → outputs stable throughout, req_ready stays 0. The first resp_ready=1 completes the handshake and the next grant follows one cycle later.
- Reset mid-CALC: assert reset at T+2 → all outputs 0 immediately, FSM in IDLE, rr_ptr=0. No stale resp_valid after release.
- Equal operands: a=b=64'hDEAD_BEEF_0123_4567 → diff=0, borrow=0.
